m_fetch_q: RTL and testbench

M_FETCH_Q -- requirements
Module: m_fetch_q

---
 rtl/m_fetch_q.sv | 146 ++++++++++++++
 tb/tb_m_fetch_q.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_fetch_q.sv
// m_fetch_q: instruction fetch queue sitting between instruction memory and decode.
// Keeps at most one fetch outstanding and buffers {pc, ir} pairs in a circular
// FIFO of DEPTH entries. A redirect flushes the queue and restarts fetching at a
// new PC. A fetch already in flight at that point is killed: its ack is dropped.
// Build option: define FETCHQ_BYPASS_EN to forward ack data straight to decode
// when the queue is empty and decode is ready.
module m_fetch_q #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                   w_clk,
    input  logic                   w_rst_n,
    input  logic                   w_redir,
    input  logic [31:0]            w_redir_pc,
    output logic                   w_imem_req,
    output logic [31:0]            w_imem_addr,
    input  logic                   w_imem_ack,
    input  logic [31:0]            w_imem_data,
    output logic                   w_dv,
    output logic [31:0]            w_dpc,
    output logic [31:0]            w_dir,
    input  logic                   w_drdy,
    output logic [$clog2(DEPTH):0] w_cnt
);

    localparam int              PW   = $clog2(DEPTH);
    localparam int              CW   = PW + 1;
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);

    logic [31:0]   pc_q [DEPTH];
    logic [31:0]   ir_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   addr_q, addr_d;
    logic          pend_q, pend_d;
    logic          kill_q, kill_d;

    logic          can_issue;
    logic          ack_v;
    logic          accept;
    logic          bypass;
    logic          push;
    logic          pop;

    // Request/acceptance decode, decode-side outputs and next-state computation.
    // A new fetch is issued combinationally once the previous one has completed.
    // This lets a memory that acks in the request cycle stream one word per cycle.
    always_comb begin
        can_issue   = w_rst_n && !pend_q && (cnt_q < FULL);
        w_imem_req  = w_rst_n && (pend_q || can_issue);
        w_imem_addr = pend_q ? addr_q : fetch_pc_q;

        ack_v  = w_imem_ack && w_imem_req;
        accept = ack_v && !kill_q && !w_redir;
`ifdef FETCHQ_BYPASS_EN
        bypass = accept && (cnt_q == '0) && w_drdy;
`else
        bypass = 1'b0;
`endif
        push = accept && !bypass;
        pop  = (cnt_q != '0) && w_drdy && !w_redir;

        w_dv  = (cnt_q != '0) || bypass;
        w_dpc = 32'h0;
        w_dir = 32'h0;
        if (cnt_q != '0) begin
            w_dpc = pc_q[head_q];
            w_dir = ir_q[head_q];
        end else if (bypass) begin
            w_dpc = w_imem_addr;
            w_dir = w_imem_data;
        end

        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (w_redir) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        fetch_pc_d = fetch_pc_q;
        if (w_redir) begin
            fetch_pc_d = w_redir_pc;
        end else if (accept) begin
            fetch_pc_d = w_imem_addr + 32'd4;
        end

        pend_d = w_imem_req && !ack_v;
        addr_d = w_imem_addr;

        kill_d = kill_q;
        if (ack_v) begin
            kill_d = 1'b0;
        end else if (w_redir && w_imem_req) begin
            kill_d = 1'b1;
        end
    end

    assign w_cnt = cnt_q;

    // Control state: pointers, occupancy, fetch PC and outstanding-request tracking.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            pend_q     <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            pend_q     <= pend_d;
            kill_q     <= kill_d;
        end
    end

    // Queue storage: write the accepted {pc, ir} at the tail slot.
    always_ff @(posedge w_clk) begin
        if (push) begin
            pc_q[tail_q] <= w_imem_addr;
            ir_q[tail_q] <= w_imem_data;
        end
    end

endmodule

// File: tb/tb_m_fetch_q.sv
// tb_m_fetch_q: randomized and directed bench for m_fetch_q.
// Uses a queue-based reference model of the fetch queue, plus a memory
// responder whose instruction words are derived from the address.
module tb_m_fetch_q;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          CW       = $clog2(DEPTH) + 1;

    logic          w_clk = 1'b0;
    logic          w_rst_n = 1'b0;
    logic          w_redir = 1'b0;
    logic [31:0]   w_redir_pc = 32'h0;
    logic          w_imem_ack = 1'b0;
    logic [31:0]   w_imem_data = 32'h0;
    logic          w_drdy = 1'b0;
    logic          w_imem_req;
    logic [31:0]   w_imem_addr;
    logic          w_dv;
    logic [31:0]   w_dpc;
    logic [31:0]   w_dir;
    logic [CW-1:0] w_cnt;

    int errors = 0;
    int checks = 0;

    // Memory responder state
    int memLat  = 0;
    int memWait = 0;

    // Reference model state
    logic [31:0] mq[$];
    logic [31:0] mFetch    = RESET_PC;
    logic [31:0] mPendAddr = RESET_PC;
    bit          mPend     = 1'b0;
    bit          mKill     = 1'b0;

    // Per-cycle snapshot of the DUT and the model
    logic          obsReq, obsDv;
    logic [31:0]   obsAddr, obsDpc, obsDir;
    logic [CW-1:0] obsCnt;
    bit            expReq, expDv;
    logic [31:0]   expAddr, expDpc, expDir;
    int            expCnt;
    logic [31:0]   obsPops[$];

    m_fetch_q #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .w_clk       (w_clk),
        .w_rst_n     (w_rst_n),
        .w_redir     (w_redir),
        .w_redir_pc  (w_redir_pc),
        .w_imem_req  (w_imem_req),
        .w_imem_addr (w_imem_addr),
        .w_imem_ack  (w_imem_ack),
        .w_imem_data (w_imem_data),
        .w_dv        (w_dv),
        .w_dpc       (w_dpc),
        .w_dir       (w_dir),
        .w_drdy      (w_drdy),
        .w_cnt       (w_cnt)
    );

    always #5 w_clk = ~w_clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // One clock cycle: drive inputs at negedge, compute the model's view,
    // snapshot DUT outputs, then advance the model as of the coming posedge.
    // ackMode: 0 = memory responder, 1 = force ack high, 2 = force ack low.
    task automatic stepCycle(input bit rst, input bit redir, input logic [31:0] rpc,
                             input bit drdy, input int ackMode);
        bit ack, ackv, acc, byp;
        @(negedge w_clk);
        w_rst_n    = rst;
        w_redir    = redir;
        w_redir_pc = rpc;
        w_drdy     = drdy;
        expReq  = rst && (mPend || (mq.size() < DEPTH));
        expAddr = mPend ? mPendAddr : mFetch;
        ack = 1'b0;
        if (ackMode == 1) begin
            ack = 1'b1;
        end else if (ackMode == 0 && expReq) begin
            if (memWait >= memLat) ack = 1'b1;
            else memWait++;
        end
        w_imem_ack  = ack;
        w_imem_data = ack ? memWord(expAddr) : 32'hDEAD_BEEF;
        ackv = ack && expReq;
        acc  = ackv && !mKill && !redir;
        byp  = 1'b0;
`ifdef FETCHQ_BYPASS_EN
        byp  = acc && (mq.size() == 0) && drdy;
`endif
        expCnt = mq.size();
        expDv  = (mq.size() != 0) || byp;
        expDpc = (mq.size() != 0) ? mq[0] : (byp ? expAddr : 32'h0);
        expDir = expDv ? memWord(expDpc) : 32'h0;
        #1;
        obsReq  = w_imem_req;
        obsAddr = w_imem_addr;
        obsDv   = w_dv;
        obsDpc  = w_dpc;
        obsDir  = w_dir;
        obsCnt  = w_cnt;
        if (rst && obsDv && drdy && !redir) obsPops.push_back(obsDpc);
        if (!rst) begin
            mq.delete();
            mFetch    = RESET_PC;
            mPendAddr = RESET_PC;
            mPend     = 1'b0;
            mKill     = 1'b0;
            memWait   = 0;
        end else begin
            if (ackv || !expReq) memWait = 0;
            if (redir) begin
                mq.delete();
                mFetch = rpc;
            end else begin
                if (mq.size() != 0 && drdy) void'(mq.pop_front());
                if (acc && !byp) mq.push_back(expAddr);
                if (acc) mFetch = expAddr + 32'd4;
            end
            if (ackv) mKill = 1'b0;
            else if (redir && expReq) mKill = 1'b1;
            mPend     = expReq && !ackv;
            mPendAddr = expAddr;
        end
    endtask

    task automatic test_reset();
        stepCycle(0, 0, 32'h0, 1, 2);
        stepCycle(0, 0, 32'h0, 1, 1);
        checks++; if (obsReq !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", obsReq); end
        checks++; if (obsDv !== 1'b0) begin errors++; $display("[TB] FAIL reset_dv: got %b expected 0", obsDv); end
        checks++; if (obsCnt !== '0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", obsCnt); end
        checks++; if (obsDpc !== 32'h0) begin errors++; $display("[TB] FAIL reset_dpc: got %h expected 0", obsDpc); end
        checks++; if (obsDir !== 32'h0) begin errors++; $display("[TB] FAIL reset_dir: got %h expected 0", obsDir); end
        stepCycle(1, 0, 32'h0, 1, 2);
        checks++; if (obsReq !== 1'b1) begin errors++; $display("[TB] FAIL first_req: got %b expected 1", obsReq); end
        checks++; if (obsAddr !== RESET_PC) begin errors++; $display("[TB] FAIL first_addr: got %h expected %h", obsAddr, RESET_PC); end
        checks++; if (obsCnt !== '0) begin errors++; $display("[TB] FAIL stray_ack_in_reset: got cnt %0d expected 0", obsCnt); end
    endtask

    task automatic test_stream();
        bit cntOk = 1'b1;
        memLat = 0;
        obsPops.delete();
        for (int i = 0; i < 12; i++) begin
            stepCycle(1, 0, 32'h0, 1, 0);
            if (obsCnt > 1) cntOk = 1'b0;
        end
        checks++; if (!cntOk) begin errors++; $display("[TB] FAIL stream_cnt: got occupancy above 1 expected at most 1"); end
        checks++; if (obsPops.size() < 8) begin errors++; $display("[TB] FAIL stream_count: got %0d pops expected at least 8", obsPops.size()); end
        for (int i = 0; i < 8 && i < obsPops.size(); i++) begin
            checks++;
            if (obsPops[i] !== 32'(4 * i)) begin
                errors++; $display("[TB] FAIL stream_pc[%0d]: got %h expected %h", i, obsPops[i], 32'(4 * i));
            end
        end
    endtask

    task automatic test_full();
        logic [31:0] want[4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        memLat = 0;
        stepCycle(1, 1, 32'h0, 0, 0);
        for (int i = 0; i < 8; i++) stepCycle(1, 0, 32'h0, 0, 0);
        checks++; if (obsCnt !== CW'(4)) begin errors++; $display("[TB] FAIL full_cnt: got %0d expected 4", obsCnt); end
        checks++; if (obsReq !== 1'b0) begin errors++; $display("[TB] FAIL full_req: got %b expected 0", obsReq); end
        checks++; if (obsDpc !== 32'h0) begin errors++; $display("[TB] FAIL full_dpc_hold: got %h expected 0", obsDpc); end
        checks++; if (obsDir !== memWord(32'h0)) begin errors++; $display("[TB] FAIL full_dir_hold: got %h expected %h", obsDir, memWord(32'h0)); end
        stepCycle(1, 0, 32'h0, 0, 1);
        stepCycle(1, 0, 32'h0, 0, 2);
        checks++; if (obsCnt !== CW'(4)) begin errors++; $display("[TB] FAIL ack_without_req: got cnt %0d expected 4", obsCnt); end
        obsPops.delete();
        for (int i = 0; i < 8; i++) stepCycle(1, 0, 32'h0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= obsPops.size() || obsPops[i] !== want[i]) begin
                errors++; $display("[TB] FAIL drain_pc[%0d]: got %h expected %h", i, (i < obsPops.size()) ? obsPops[i] : 32'hX, want[i]);
            end
        end
    endtask

    task automatic test_redirect_pending();
        int n = 0;
        memLat = 2;
        stepCycle(1, 1, 32'h40, 1, 0);
        do begin stepCycle(1, 0, 32'h0, 1, 0); n++; end
        while (!(obsReq === 1'b1 && obsAddr === 32'h40) && n < 12);
        checks++; if (n >= 12) begin errors++; $display("[TB] FAIL redir_issue_timeout: got no request to 00000040 expected one"); end
        stepCycle(1, 1, 32'h100, 1, 0);
        stepCycle(1, 0, 32'h0, 1, 0);
        checks++; if (obsAddr !== 32'h40) begin errors++; $display("[TB] FAIL killed_addr_stable: got %h expected 00000040", obsAddr); end
        stepCycle(1, 0, 32'h0, 1, 0);
        checks++; if (obsReq !== 1'b1 || obsAddr !== 32'h100) begin errors++; $display("[TB] FAIL refetch_addr: got req %b addr %h expected req 1 addr 00000100", obsReq, obsAddr); end
        obsPops.delete();
        n = 0;
        while (obsPops.size() == 0 && n < 12) begin stepCycle(1, 0, 32'h0, 1, 0); n++; end
        checks++; if (obsPops.size() == 0 || obsPops[0] !== 32'h100) begin errors++; $display("[TB] FAIL redir_first_dpc: got %h expected 00000100", (obsPops.size() != 0) ? obsPops[0] : 32'hX); end
    endtask

    task automatic test_redir_ack();
        int n = 0;
        memLat = 0;
        stepCycle(1, 1, 32'h500, 0, 0);
        while (mq.size() != 2 && n < 10) begin stepCycle(1, 0, 32'h0, 0, 0); n++; end
        stepCycle(1, 1, 32'h700, 0, 0);
        checks++; if (obsCnt !== CW'(2) || obsReq !== 1'b1) begin errors++; $display("[TB] FAIL redir_ack_setup: got cnt %0d req %b expected cnt 2 req 1", obsCnt, obsReq); end
        stepCycle(1, 0, 32'h0, 0, 2);
        checks++; if (obsCnt !== '0) begin errors++; $display("[TB] FAIL redir_ack_cnt: got %0d expected 0", obsCnt); end
        checks++; if (obsDv !== 1'b0) begin errors++; $display("[TB] FAIL redir_ack_dv: got %b expected 0", obsDv); end
        obsPops.delete();
        n = 0;
        while (obsPops.size() == 0 && n < 10) begin stepCycle(1, 0, 32'h0, 1, 0); n++; end
        checks++; if (obsPops.size() == 0 || obsPops[0] !== 32'h700) begin errors++; $display("[TB] FAIL redir_ack_first: got %h expected 00000700", (obsPops.size() != 0) ? obsPops[0] : 32'hX); end
    endtask

    task automatic test_wrap();
        memLat = 0;
        obsPops.delete();
        stepCycle(1, 1, 32'hFFFF_FFFC, 1, 0);
        for (int i = 0; i < 6; i++) stepCycle(1, 0, 32'h0, 1, 0);
        checks++; if (obsPops.size() < 2 || obsPops[0] !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_pc0: got %h expected fffffffc", (obsPops.size() != 0) ? obsPops[0] : 32'hX); end
        checks++; if (obsPops.size() < 2 || obsPops[1] !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc1: got %h expected 00000000", (obsPops.size() > 1) ? obsPops[1] : 32'hX); end
    endtask

    task automatic test_back_to_back();
        memLat = 1;
        stepCycle(1, 1, 32'h200, 1, 0);
        obsPops.delete();
        stepCycle(1, 1, 32'h300, 1, 0);
        for (int i = 0; i < 10; i++) stepCycle(1, 0, 32'h0, 1, 0);
        checks++; if (obsPops.size() == 0 || obsPops[0] !== 32'h300) begin errors++; $display("[TB] FAIL back_to_back_first: got %h expected 00000300", (obsPops.size() != 0) ? obsPops[0] : 32'hX); end
    endtask

    task automatic test_reset_midburst();
        int n = 0;
        memLat = 2;
        stepCycle(1, 0, 32'h0, 1, 0);
        while (!mPend && n < 10) begin stepCycle(1, 0, 32'h0, 1, 0); n++; end
        checks++; if (!mPend) begin errors++; $display("[TB] FAIL midburst_setup: got no pending request expected one"); end
        stepCycle(0, 0, 32'h0, 1, 2);
        stepCycle(0, 0, 32'h0, 1, 1);
        checks++; if (obsReq !== 1'b0 || obsDv !== 1'b0 || obsCnt !== '0) begin errors++; $display("[TB] FAIL midburst_ctrl: got req %b dv %b cnt %0d expected 0 0 0", obsReq, obsDv, obsCnt); end
        checks++; if (obsDpc !== 32'h0 || obsDir !== 32'h0) begin errors++; $display("[TB] FAIL midburst_data: got dpc %h dir %h expected 0 0", obsDpc, obsDir); end
        stepCycle(1, 0, 32'h0, 1, 2);
        checks++; if (obsCnt !== '0) begin errors++; $display("[TB] FAIL stale_ack: got cnt %0d expected 0", obsCnt); end
        checks++; if (obsReq !== 1'b1 || obsAddr !== RESET_PC) begin errors++; $display("[TB] FAIL restart_req: got req %b addr %h expected 1 %h", obsReq, obsAddr, RESET_PC); end
        memLat = 0;
        stepCycle(1, 0, 32'h0, 1, 0);
`ifdef FETCHQ_BYPASS_EN
        checks++; if (obsDv !== 1'b1 || obsDpc !== RESET_PC || obsDir !== memWord(RESET_PC)) begin errors++; $display("[TB] FAIL bypass_first: got dv %b dpc %h dir %h expected 1 %h %h", obsDv, obsDpc, obsDir, RESET_PC, memWord(RESET_PC)); end
`else
        checks++; if (obsDv !== 1'b0) begin errors++; $display("[TB] FAIL latency_ack_cycle: got dv %b expected 0", obsDv); end
        stepCycle(1, 0, 32'h0, 1, 0);
        checks++; if (obsDv !== 1'b1 || obsDpc !== RESET_PC || obsDir !== memWord(RESET_PC)) begin errors++; $display("[TB] FAIL latency_next_cycle: got dv %b dpc %h dir %h expected 1 %h %h", obsDv, obsDpc, obsDir, RESET_PC, memWord(RESET_PC)); end
`endif
    endtask

    task automatic test_random();
        bit rst, redir, drdy;
        logic [31:0] rpc;
        for (int i = 0; i < 400; i++) begin
            if (memWait == 0) memLat = $urandom_range(0, 3);
            rst   = ($urandom_range(0, 63) != 0);
            redir = ($urandom_range(0, 15) == 0);
            drdy  = ($urandom_range(0, 3) != 0);
            rpc   = $urandom() & 32'hFFFF_FFFC;
            stepCycle(rst, redir, rpc, drdy, 0);
            checks++; if (obsReq !== expReq) begin errors++; $display("[TB] FAIL rand_req @%0d: got %b expected %b", i, obsReq, expReq); end
            if (expReq) begin
                checks++; if (obsAddr !== expAddr) begin errors++; $display("[TB] FAIL rand_addr @%0d: got %h expected %h", i, obsAddr, expAddr); end
            end
            checks++; if (obsCnt !== CW'(expCnt)) begin errors++; $display("[TB] FAIL rand_cnt @%0d: got %0d expected %0d", i, obsCnt, expCnt); end
            checks++; if (obsDv !== expDv) begin errors++; $display("[TB] FAIL rand_dv @%0d: got %b expected %b", i, obsDv, expDv); end
            if (expDv) begin
                checks++; if (obsDpc !== expDpc) begin errors++; $display("[TB] FAIL rand_dpc @%0d: got %h expected %h", i, obsDpc, expDpc); end
                checks++; if (obsDir !== expDir) begin errors++; $display("[TB] FAIL rand_dir @%0d: got %h expected %h", i, obsDir, expDir); end
            end
        end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect_pending();
        test_redir_ack();
        test_wrap();
        test_back_to_back();
        test_reset_midburst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
